// File: rtl/ref_fetch_pkg.sv
// Shared types and defaults for the reference row fetcher.
// Holds frame geometry defaults, the FSM state enum and the coordinate type.
package ref_fetch_pkg;

  localparam int PIX_W_D   = 8;
  localparam int ROW_PIX_D = 15;
  localparam int FRAME_W_D = 400;
  localparam int FRAME_H_D = 300;
  localparam int MEM_AW_D  = 17;
  localparam int COORD_W   = 12;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef logic signed [COORD_W-1:0] coord_t;

endpackage

// File: rtl/ref_coord_clamp.sv
// Pixel coordinate to frame address (x, y -> addr, in_frame), combinational.
// REF_PAD_EN: clamp to frame edges, in_frame=1; else range-check only.
module ref_coord_clamp
  import ref_fetch_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_D,
  parameter int FRAME_H = FRAME_H_D,
  parameter int MEM_AW  = MEM_AW_D
) (
  input  coord_t              x,
  input  coord_t              y,
  output logic [MEM_AW-1:0]   addr,
  output logic                in_frame
);

  localparam coord_t XMAX = coord_t'(FRAME_W - 1);
  localparam coord_t YMAX = coord_t'(FRAME_H - 1);

  logic   x_lo, x_hi, y_lo, y_hi;
  coord_t xc, yc;

  assign x_lo = x[COORD_W-1];
  assign y_lo = y[COORD_W-1];
  assign x_hi = x > XMAX;
  assign y_hi = y > YMAX;

  always_comb begin
`ifdef REF_PAD_EN
    xc       = x_lo ? '0 : (x_hi ? XMAX : x);
    yc       = y_lo ? '0 : (y_hi ? YMAX : y);
    in_frame = 1'b1;
`else
    xc       = x;
    yc       = y;
    in_frame = ~(x_lo | x_hi | y_lo | y_hi);
`endif
  end

  // Only meaningful when in_frame; no wrap-around is attempted.
  assign addr = MEM_AW'($unsigned(yc)) * MEM_AW'(FRAME_W)
              + MEM_AW'($unsigned(xc));

endmodule

// File: rtl/ref_row_fetcher.sv
// Fetches one 15-pixel window row from byte-wide frame memory into in_row.
// Ports: req_* handshake, mem_* read port, in_row/row_valid/row_idx, req_err. Option: REF_PAD_EN.
module ref_row_fetcher
  import ref_fetch_pkg::*;
#(
  parameter int PIX_W   = PIX_W_D,
  parameter int ROW_PIX = ROW_PIX_D,
  parameter int FRAME_W = FRAME_W_D,
  parameter int FRAME_H = FRAME_H_D,
  parameter int MEM_AW  = MEM_AW_D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [11:0]         blk_x,
  input  logic signed [11:0]         blk_y,
  input  logic                       req_valid,
  input  logic [7:0]                 req_row,
  output logic                       req_ready,
  output logic                       mem_rd_en,
  output logic [MEM_AW-1:0]          mem_addr,
  input  logic [PIX_W-1:0]           mem_rd_data,
  output logic [PIX_W*ROW_PIX-1:0]   in_row,
  output logic                       row_valid,
  output logic [7:0]                 row_idx,
  output logic                       req_err
);

  localparam int            CW   = $clog2(ROW_PIX);
  localparam logic [CW-1:0] LAST = CW'(ROW_PIX - 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              col_q, dcol_q;
  logic                       cap_q, rd_q;
  logic                       err_q, row_valid_q;
  logic [7:0]                 row_q, row_idx_q;
  coord_t                     bx_q, by_q, px, py;
  logic [MEM_AW-1:0]          caddr, addr_q;
  logic                       in_frame, req_ok, accept;
  logic [PIX_W*ROW_PIX-1:0]   in_row_q;

  assign req_ok = req_row < 8'(ROW_PIX);
  assign accept = req_ready & req_valid & req_ok;

  assign px = bx_q + coord_t'(col_q);
  assign py = by_q + coord_t'(row_q);

  ref_coord_clamp #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .MEM_AW  (MEM_AW)
  ) u_clamp (
    .x        (px),
    .y        (py),
    .addr     (caddr),
    .in_frame (in_frame)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (accept) state_d = ISSUE;
      ISSUE:      if (col_q == LAST) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    unique case (state_q)
      IDLE, DONE: req_ready = 1'b1;
      ISSUE:      mem_rd_en = in_frame;
      default:    ;
    endcase
    // Skipped out-of-frame columns leave the bus address parked.
    mem_addr = mem_rd_en ? caddr : addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      dcol_q      <= '0;
      cap_q       <= 1'b0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      row_valid_q <= 1'b0;
      row_q       <= '0;
      row_idx_q   <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      addr_q      <= '0;
      in_row_q    <= '0;
    end else begin
      err_q  <= req_ready & req_valid & ~req_ok;
      dcol_q <= col_q;
      cap_q  <= state_q == ISSUE;
      rd_q   <= mem_rd_en;
      if (mem_rd_en) addr_q <= caddr;
      if (state_q == ISSUE) col_q <= col_q + 1'b1;
      if (accept) begin
        row_q       <= req_row;
        bx_q        <= blk_x;
        by_q        <= blk_y;
        col_q       <= '0;
        row_valid_q <= 1'b0;
      end
      // Slot chosen by the delayed column, so skipped reads still land in place.
      if (cap_q)
        in_row_q[dcol_q*PIX_W +: PIX_W] <= rd_q ? mem_rd_data : '0;
      if (state_q == DRAIN) begin
        row_valid_q <= 1'b1;
        row_idx_q   <= row_q;
      end
    end
  end

  assign in_row    = in_row_q;
  assign row_valid = row_valid_q;
  assign row_idx   = row_idx_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_ref_row_fetcher.sv
// Scoreboard bench for ref_row_fetcher with a behavioural frame memory.
// pixel(x,y) = (x+3y) mod 256; checks reads, rows, latency, errors, reset.
module tb_ref_row_fetcher;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [11:0]    blk_x = '0, blk_y = '0;
  logic           req_valid = 1'b0;
  logic [7:0]     req_row = '0;
  logic           req_ready, mem_rd_en;
  logic [16:0]    mem_addr;
  logic [7:0]     mem_rd_data = '0;
  logic [119:0]   in_row;
  logic           row_valid;
  logic [7:0]     row_idx;
  logic           req_err;

  ref_row_fetcher dut (
    .clk         (clk),
    .rst         (rst),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .req_valid   (req_valid),
    .req_row     (req_row),
    .req_ready   (req_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .in_row      (in_row),
    .row_valid   (row_valid),
    .row_idx     (row_idx),
    .req_err     (req_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_rd_en)
      mem_rd_data <= 8'((int'(mem_addr) % 400 + 3 * (int'(mem_addr) / 400)) % 256);

  typedef struct {
    int           row;
    logic [119:0] data;
    int           due;
  } exp_t;

  exp_t rq[$];
  int   aq[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit pix_at(input int x, input int y, output int a);
    int xx, yy;
    xx = x;
    yy = y;
    a  = 0;
`ifdef REF_PAD_EN
    if (xx < 0) xx = 0;
    if (xx > 399) xx = 399;
    if (yy < 0) yy = 0;
    if (yy > 299) yy = 299;
`else
    if (xx < 0 || xx > 399 || yy < 0 || yy > 299) return 1'b0;
`endif
    a = yy * 400 + xx;
    return 1'b1;
  endfunction

  function automatic logic [119:0] row_model(input int bx, input int by,
                                             input int r);
    logic [119:0] d;
    int a;
    d = '0;
    for (int k = 0; k < 15; k++)
      if (pix_at(bx + k, by + r, a))
        d[8*k +: 8] = 8'((bx + k + 3 * (by + r)) % 256);
`ifdef REF_PAD_EN
    for (int k = 0; k < 15; k++)
      if (pix_at(bx + k, by + r, a))
        d[8*k +: 8] = 8'((a % 400 + 3 * (a / 400)) % 256);
`endif
    return d;
  endfunction

  task automatic plan(input int bx, input int by, input int r, input int due);
    exp_t e;
    int a;
    for (int k = 0; k < 15; k++)
      if (pix_at(bx + k, by + r, a)) aq.push_back(a);
    e.row  = r;
    e.data = row_model(bx, by, r);
    e.due  = due;
    rq.push_back(e);
  endtask

  logic rv_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      rv_prev = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (aq.size() == 0) check("rd_unexpected", 128'(mem_rd_en), 128'(0));
        else check("rd_addr", 128'(mem_addr), 128'(aq.pop_front()));
      end
      if (row_valid && !rv_prev) begin
        if (rq.size() == 0) begin
          check("row_unexpected", 128'(row_valid), 128'(0));
        end else begin
          exp_t e;
          e = rq.pop_front();
          check("row_idx", 128'(row_idx), 128'(e.row));
          check("in_row", 128'(in_row), 128'(e.data));
          check("row_latency", 128'(cyc), 128'(e.due));
        end
      end
      rv_prev = row_valid;
    end
  end

  // Called and returns at #1 after a rising edge.
  task automatic req(input int r, input int bx, input int by, output int t);
    int w;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) check("ready_timeout", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_row   = 8'(r);
    blk_x     = 12'(bx);
    blk_y     = 12'(by);
    t         = cyc;
    plan(bx, by, r, t + 17);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((rq.size() != 0 || aq.size() != 0) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 300) check("drain_timeout", 128'(rq.size()), 128'(0));
  endtask

  task automatic bad_req(input logic [7:0] r, input logic exp_rv,
                         input logic [119:0] exp_row);
    req_valid = 1'b1;
    req_row   = r;
    blk_x     = 12'(5);
    blk_y     = 12'(5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("err_pulse", 128'(req_err), 128'(1));
    check("err_rv_held", 128'(row_valid), 128'(exp_rv));
    check("err_row_held", 128'(in_row), 128'(exp_row));
    @(posedge clk); #1;
    check("err_one_cycle", 128'(req_err), 128'(0));
    check("err_ready", 128'(req_ready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, tp;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(req_ready), 128'(1));
    check("rst_rd_en", 128'(mem_rd_en), 128'(0));
    check("rst_addr", 128'(mem_addr), 128'(0));
    check("rst_in_row", 128'(in_row), 128'(0));
    check("rst_row_valid", 128'(row_valid), 128'(0));
    check("rst_row_idx", 128'(row_idx), 128'(0));
    check("rst_req_err", 128'(req_err), 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    bad_req(8'd15, 1'b0, '0);

    req(4, 10, 20, t);
    wait_idle();

    bad_req(8'd200, 1'b1, row_model(10, 20, 4));
    check("err_idx_held", 128'(row_idx), 128'(4));

    req(3, 10, 20, t);
    repeat (4) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_row   = 8'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    tp = 0;
    for (int r = 0; r < 15; r++) begin
      req(r, 100, 50, t);
      if (r > 0) check("b2b_gap", 128'(t - tp), 128'(17));
      tp = t;
    end
    wait_idle();

    req(0, -3, -3, t);
    req(3, -3, -3, t);
    wait_idle();
    req(1, 392, 298, t);
    wait_idle();

    req(5, 30, 40, t);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_rd_en", 128'(mem_rd_en), 128'(0));
    check("mid_rst_rv", 128'(row_valid), 128'(0));
    check("mid_rst_in_row", 128'(in_row), 128'(0));
    check("mid_rst_ready", 128'(req_ready), 128'(1));
    rq.delete();
    aq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req(2, 30, 40, t);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
